// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: drives every input vector of a small combinational
// function in ascending order, samples its output after a settle interval,
// builds the truth table and compares it against a golden table.
//
// Handshake: i_start is a request that is accepted only on a clock edge
// where the engine is idle (o_busy low, o_done low); requests in any other
// cycle are dropped, not queued. o_busy is high from the accept edge until
// the completing edge; o_done is a one-cycle pulse on completion, and the
// result outputs are stable from that pulse until the next accepted start.
module tt_sweep_checker #(
  parameter int unsigned           N_IN     = 3,
  parameter int unsigned           SETTLE   = 1,
  parameter logic [(2**N_IN)-1:0]  EXPECTED = 8'hAC
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic                     i_s_in,
  output logic [N_IN-1:0]          o_vec_out,
  output logic                     o_busy,
  output logic                     o_done,
  output logic [(2**N_IN)-1:0]     o_table_out,
  output logic [N_IN:0]            o_err_count,
  output logic [N_IN-1:0]          o_first_err_idx,
  output logic                     o_pass,
  output logic [1:0]               o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN-1:0] VEC_ONE  = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_settle_cnt;
  logic [N_IN-1:0]         r_vec_out;
  logic                    r_busy;
  logic                    r_done;
  logic [(2**N_IN)-1:0]    r_table_out;
  logic [N_IN:0]           r_err_count;
  logic [N_IN-1:0]         r_first_err_idx;
  logic                    r_pass;

  logic                    w_sample;
  logic                    w_last;
  logic                    w_mismatch;
  logic [N_IN:0]           w_err_next;

  // Sampling edge: the current vector has been held for SETTLE+1 cycles.
  assign w_sample   = (r_state == ST_DRIVE) && (r_settle_cnt == SETTLE_C);
  assign w_last     = (r_vec_out == LAST_VEC);
  assign w_mismatch = (i_s_in != EXPECTED[r_vec_out]);
  // Error count including this cycle's comparison, so pass reflects the last vector.
  assign w_err_next = w_mismatch ? (r_err_count + ERR_ONE) : r_err_count;

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (i_start) w_state_nxt = ST_DRIVE;
      ST_DRIVE: if (w_sample && w_last) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Sweep datapath: vector stepping, settle timing, capture and scoring.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_settle_cnt    <= '0;
      r_vec_out       <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_table_out     <= '0;
      r_err_count     <= '0;
      r_first_err_idx <= '0;
      r_pass          <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_settle_cnt    <= '0;
            r_vec_out       <= '0;
            r_busy          <= 1'b1;
            r_table_out     <= '0;
            r_err_count     <= '0;
            r_first_err_idx <= '0;
            r_pass          <= 1'b0;
          end
        end
        ST_DRIVE: begin
          if (!w_sample) begin
            r_settle_cnt <= r_settle_cnt + 4'd1;
          end else begin
            r_table_out[r_vec_out] <= i_s_in;
            r_err_count            <= w_err_next;
            if (w_mismatch && (r_err_count == '0)) r_first_err_idx <= r_vec_out;
            if (w_last) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
              r_pass <= (w_err_next == '0);
            end else begin
              r_vec_out    <= r_vec_out + VEC_ONE;
              r_settle_cnt <= '0;
            end
          end
        end
        ST_DONE: begin
          r_done <= 1'b0;
        end
        default: begin
          r_done <= 1'b0;
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_vec_out       = r_vec_out;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_table_out     = r_table_out;
  assign o_err_count     = r_err_count;
  assign o_first_err_idx = r_first_err_idx;
  assign o_pass          = r_pass;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Bench for tt_sweep_checker: three builds (SETTLE = 0, 1, 3) driven by
// functions whose output lags the vector by exactly SETTLE cycles, checked
// against a truth-table model evaluated directly from the boolean function.
module tb_tt_sweep_checker;

  localparam logic [7:0] EXP = 8'hAC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // ---------------- DUT signals ----------------
  logic       start0, start1, start3;
  logic       s_in0, s_in1, s_in3;
  logic [2:0] vec0, vec1, vec3;
  logic       busy0, busy1, busy3, done0, done1, done3;
  logic [7:0] tbl0, tbl1, tbl3;
  logic [3:0] err0, err1, err3;
  logic [2:0] fst0, fst1, fst3;
  logic       pass0, pass1, pass3;
  logic [1:0] st0, st1, st3;

  int         mode;   // 0 model, 1 tied 0, 2 inverted model, 3 random table
  logic [7:0] rtbl;
  int         sel;    // which build is observed: 0, 1 or 3 (= its SETTLE)
  int         n_cmp = 0;
  int         n_bad = 0;

  tt_sweep_checker #(.N_IN(3), .SETTLE(0), .EXPECTED(8'hAC)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .i_s_in(s_in0),
    .o_vec_out(vec0), .o_busy(busy0), .o_done(done0), .o_table_out(tbl0),
    .o_err_count(err0), .o_first_err_idx(fst0), .o_pass(pass0), .o_dbg_state(st0));

  tt_sweep_checker #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hAC)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start1), .i_s_in(s_in1),
    .o_vec_out(vec1), .o_busy(busy1), .o_done(done1), .o_table_out(tbl1),
    .o_err_count(err1), .o_first_err_idx(fst1), .o_pass(pass1), .o_dbg_state(st1));

  tt_sweep_checker #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hAC)) dut3 (
    .i_clk(clk), .i_rst(rst), .i_start(start3), .i_s_in(s_in3),
    .o_vec_out(vec3), .o_busy(busy3), .o_done(done3), .o_table_out(tbl3),
    .o_err_count(err3), .o_first_err_idx(fst3), .o_pass(pass3), .o_dbg_state(st3));

  // ---------------- function under check ----------------
  function automatic logic func(input int m, input logic [2:0] v, input logic [7:0] t);
    logic a, b, c, s;
    a = v[2]; b = v[1]; c = v[0];
    s = (~a | c) & (a | b) & (b | c);
    case (m)
      0:       return s;
      1:       return 1'b0;
      2:       return ~s;
      default: return t[v];
    endcase
  endfunction

  // Slow-logic emulation: output follows the vector after SETTLE cycles.
  logic [2:0] v1_d, v3_d1, v3_d2, v3_d3;
  always @(posedge clk) begin
    v1_d  <= vec1;
    v3_d1 <= vec3;
    v3_d2 <= v3_d1;
    v3_d3 <= v3_d2;
  end
  assign s_in0 = func(mode, vec0, rtbl);
  assign s_in1 = func(mode, v1_d, rtbl);
  assign s_in3 = func(mode, v3_d3, rtbl);

  // Observed outputs packed: {done,busy,vec[2:0],table[7:0],err[3:0],first[2:0],pass}
  logic [20:0] pack0, pack1, pack3, sel_pack;
  assign pack0 = {done0, busy0, vec0, tbl0, err0, fst0, pass0};
  assign pack1 = {done1, busy1, vec1, tbl1, err1, fst1, pass1};
  assign pack3 = {done3, busy3, vec3, tbl3, err3, fst3, pass3};
  assign sel_pack = (sel == 0) ? pack0 : (sel == 1) ? pack1 : pack3;

  // ---------------- reference model ----------------
  function automatic void model(input int m, input logic [7:0] t, output logic [7:0] tb_o,
                                output logic [3:0] ec, output logic [2:0] fi, output logic ps);
    tb_o = '0;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      tb_o[i] = func(m, v, t);
    end
    ec = '0;
    fi = '0;
    for (int i = 7; i >= 0; i--) begin
      if (tb_o[i] !== EXP[i]) begin
        ec = ec + 4'd1;
        fi = 3'(i);
      end
    end
    ps = (ec == 4'd0);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_start(input int s, input logic v);
    case (s)
      0:       start0 = v;
      1:       start1 = v;
      default: start3 = v;
    endcase
  endtask

  // Pulse start, then follow the sweep to done. Reports cycles from the
  // accept edge to the done edge and how many cycles had a wrong vec/busy.
  task automatic sweep(input int s, input bit repulse, output int cyc, output int step_bad);
    sel = s;
    set_start(s, 1'b1);
    @(posedge clk); #1;
    set_start(s, 1'b0);
    cyc = 0;
    step_bad = 0;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      set_start(s, repulse && (cyc == 3 || cyc == 10));
      if (sel_pack[20] === 1'b1) break;
      if (sel_pack[18:16] !== 3'(cyc / (s + 1)) || sel_pack[19] !== 1'b1) step_bad++;
      if (cyc >= 200) break;
    end
    set_start(s, 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (pack0 !== '0) begin n_bad++; $display("FAIL reset_s0: got %h expected 0", pack0); end
    n_cmp++; if (pack1 !== '0) begin n_bad++; $display("FAIL reset_s1: got %h expected 0", pack1); end
    n_cmp++; if (pack3 !== '0) begin n_bad++; $display("FAIL reset_s3: got %h expected 0", pack3); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_sweep(input string name, input int m, input int s, input bit repulse);
    int cyc, bad;
    logic [7:0] tb_o;
    logic [3:0] ec;
    logic [2:0] fi;
    logic ps;
    logic [20:0] exp_pack;
    mode = m;
    model(m, rtbl, tb_o, ec, fi, ps);
    sweep(s, repulse, cyc, bad);
    n_cmp++; if (cyc !== 8 * (s + 1)) begin n_bad++; $display("FAIL %s_latency: got %0d expected %0d", name, cyc, 8 * (s + 1)); end
    n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL %s_vec_step: got %0d bad cycles expected 0", name, bad); end
    exp_pack = {1'b1, 1'b0, 3'd7, tb_o, ec, fi, ps};
    n_cmp++; if (sel_pack !== exp_pack) begin n_bad++; $display("FAIL %s_results: got %h expected %h", name, sel_pack, exp_pack); end
    @(posedge clk); #1;
    exp_pack[20] = 1'b0;
    n_cmp++; if (sel_pack !== exp_pack) begin n_bad++; $display("FAIL %s_after_done: got %h expected %h", name, sel_pack, exp_pack); end
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (sel_pack !== exp_pack) begin n_bad++; $display("FAIL %s_hold: got %h expected %h", name, sel_pack, exp_pack); end
  endtask

  task automatic test_reset_mid();
    int k;
    mode = 0;
    sel = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    while (vec1 !== 3'd3 && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    n_cmp++; if (k >= 50) begin n_bad++; $display("FAIL reset_mid_reach: got vec %0d expected 3", vec1); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (pack1 !== '0) begin n_bad++; $display("FAIL reset_mid_clear: got %h expected 0", pack1); end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (pack1 !== '0) begin n_bad++; $display("FAIL reset_mid_idle: got %h expected 0", pack1); end
    test_sweep("after_reset", 0, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int cyc;
    mode = 0;
    sel = 1;
    start1 = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL b2b_first_latency: got %0d expected 16", cyc); end
    @(posedge clk); #1;
    n_cmp++; if ({done1, busy1} !== 2'b00) begin n_bad++; $display("FAIL b2b_gap: got done/busy %b expected 00", {done1, busy1}); end
    @(posedge clk); #1;
    start1 = 1'b0;
    n_cmp++; if ({busy1, vec1, tbl1, err1} !== {1'b1, 3'd0, 8'h00, 4'd0}) begin
      n_bad++; $display("FAIL b2b_rearm: got busy %b vec %0d table %h err %0d expected 1 0 00 0", busy1, vec1, tbl1, err1);
    end
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_cmp++; if (cyc !== 16) begin n_bad++; $display("FAIL b2b_second_latency: got %0d expected 16", cyc); end
    n_cmp++; if ({tbl1, err1, pass1} !== {8'hAC, 4'd0, 1'b1}) begin
      n_bad++; $display("FAIL b2b_results: got table %h err %0d pass %b expected ac 0 1", tbl1, err1, pass1);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    int s;
    mode = 3;
    for (int r = 0; r < 6; r++) begin
      rtbl = 8'($urandom);
      case ($urandom_range(0, 2))
        0:       s = 0;
        1:       s = 1;
        default: s = 3;
      endcase
      test_sweep("random", 3, s, 1'b0);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start3 = 1'b0;
    mode = 0;
    rtbl = 8'h00;
    sel = 1;
    test_reset();
    test_sweep("correct", 0, 1, 1'b0);
    test_sweep("tied_zero", 1, 1, 1'b0);
    test_sweep("inverted", 2, 1, 1'b0);
    test_sweep("ignore_start", 0, 1, 1'b1);
    test_reset_mid();
    test_sweep("settle0", 0, 0, 1'b0);
    test_sweep("settle3", 0, 3, 1'b0);
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
